// File: rtl/bram_stream_fifo_pkg.sv
// rtl/bram_stream_fifo_pkg.sv - sizing helpers shared by the BRAM stream FIFO files
package bram_stream_fifo_pkg;

    // One credit per BRAM stage, one for the landing register, one for the word being consumed.
    function automatic int skid_depth(input int read_latency);
        return read_latency + 2;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bram_sdp_lat.sv
// rtl/bram_sdp_lat.sv - inferred simple-dual-port BRAM with a configurable read pipeline
module bram_sdp_lat #(
    parameter int DEPTH        = 1024,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int AW           = 10
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [AW-1:0]         wadd,
    input  logic [DATA_WIDTH-1:0] win,
    input  logic                  ren,
    input  logic [AW-1:0]         radd,
    output logic [DATA_WIDTH-1:0] wout
);

    logic [DATA_WIDTH-1:0] mem    [DEPTH];
    logic [DATA_WIDTH-1:0] pipe_q [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[wadd] <= win;
        end
    end

    // Later stages shift every cycle; the caller's valid pipe says which contents matter.
    always_ff @(posedge clk) begin
        if (ren) begin
            pipe_q[0] <= mem[radd];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign wout = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/bram_stream_fifo.sv
// rtl/bram_stream_fifo.sv - streaming FIFO on an inferred BRAM with credit-based prefetch skid
module bram_stream_fifo
    import bram_stream_fifo_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int ALMOST_FULL  = 896
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_WIDTH-1:0]                  s_tdata,
    input  logic                                   s_tvalid,
    output logic                                   s_tready,
    output logic [DATA_WIDTH-1:0]                  m_tdata,
    output logic                                   m_tvalid,
    input  logic                                   m_tready,
    output logic [$clog2(DEPTH+READ_LATENCY+2):0]  fill,
    output logic                                   almost_full
);

    localparam int SKID_DEPTH = skid_depth(READ_LATENCY);
    localparam int AW  = ptr_width(DEPTH);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int KW  = $clog2(SKID_DEPTH + 1);
    localparam int SIW = $clog2(SKID_DEPTH);
    localparam int FW  = $clog2(DEPTH + READ_LATENCY + 2) + 1;

    logic                    ready_q;
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [CW-1:0]           mem_count_q, mem_count_d;
    logic [KW-1:0]           credits_q, credits_d;
    logic [READ_LATENCY-1:0] vld_q;
    logic                    land_q;
    logic [DATA_WIDTH-1:0]   land_data_q;
    logic [DATA_WIDTH-1:0]   skid_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0]   skid_d [SKID_DEPTH];
    logic [KW-1:0]           skid_cnt_q, skid_cnt_d;
    logic                    almost_full_q;
    logic [DATA_WIDTH-1:0]   bram_rdata;
    logic                    wr_en, rd_en, pop;
    logic [FW-1:0]           fill_sum;

    assign s_tready    = ready_q && (mem_count_q != CW'(DEPTH));
    assign m_tvalid    = (skid_cnt_q != '0);
    assign m_tdata     = skid_q[0];
    assign almost_full = almost_full_q;
    assign fill        = fill_sum;

    assign wr_en = s_tvalid && s_tready;
    assign pop   = m_tvalid && m_tready;
    // A credit freed by this cycle's pop is reusable immediately, keeping 1 word/cycle.
    assign rd_en = (mem_count_q != '0) && ((credits_q != '0) || pop);

    always_comb begin
        mem_count_d = mem_count_q;
        if (wr_en && !rd_en) begin
            mem_count_d = mem_count_q + CW'(1);
        end else if (!wr_en && rd_en) begin
            mem_count_d = mem_count_q - CW'(1);
        end
        credits_d = credits_q - KW'(rd_en) + KW'(pop);
    end

    // Shift-down skid; the head register is left untouched when the last word leaves.
    always_comb begin
        skid_d     = skid_q;
        skid_cnt_d = skid_cnt_q;
        if (pop) begin
            for (int i = 0; i < SKID_DEPTH - 1; i++) begin
                if ((i + 1) < int'(skid_cnt_q)) begin
                    skid_d[i] = skid_q[i+1];
                end
            end
            skid_cnt_d = skid_cnt_q - KW'(1);
        end
        if (land_q) begin
            skid_d[skid_cnt_d[SIW-1:0]] = land_data_q;
            skid_cnt_d = skid_cnt_d + KW'(1);
        end
    end

    always_comb begin
        fill_sum = FW'(mem_count_q) + FW'(skid_cnt_q) + FW'(land_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            fill_sum = fill_sum + FW'(vld_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q       <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            mem_count_q   <= '0;
            credits_q     <= KW'(SKID_DEPTH);
            vld_q         <= '0;
            land_q        <= 1'b0;
            skid_cnt_q    <= '0;
            almost_full_q <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_q[i] <= '0;
            end
        end else begin
            ready_q       <= 1'b1;
            if (wr_en) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_en) begin
                rptr_q <= rptr_q + AW'(1);
            end
            mem_count_q   <= mem_count_d;
            credits_q     <= credits_d;
            vld_q         <= READ_LATENCY'({vld_q, rd_en});
            land_q        <= vld_q[READ_LATENCY-1];
            skid_q        <= skid_d;
            skid_cnt_q    <= skid_cnt_d;
            almost_full_q <= (mem_count_d >= CW'(ALMOST_FULL));
        end
    end

    always_ff @(posedge clk) begin
        land_data_q <= bram_rdata;
    end

    bram_sdp_lat #(
        .DEPTH        (DEPTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY),
        .AW           (AW)
    ) u_bram (
        .clk  (clk),
        .wen  (wr_en),
        .wadd (wptr_q),
        .win  (s_tdata),
        .ren  (rd_en),
        .radd (rptr_q),
        .wout (bram_rdata)
    );

endmodule

// File: tb/tb_bram_stream_fifo.sv
// tb/tb_bram_stream_fifo.sv - queue-model bench for bram_stream_fifo at read latency 1 and 2
`timescale 1ns/1ps
module tb_bram_stream_fifo;

    localparam int DEPTH = 1024;
    localparam int DW    = 32;
    localparam int AF    = 896;
    localparam int FW    = $clog2(DEPTH + 4) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata     [2];
    logic          s_tvalid    [2];
    logic          s_tready    [2];
    logic [DW-1:0] m_tdata     [2];
    logic          m_tvalid    [2];
    logic          m_tready    [2];
    logic [FW-1:0] fill        [2];
    logic          almost_full [2];

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q [$];
    bit            s_acc, m_pop, obs_valid, obs_ready, obs_af;
    logic [DW-1:0] obs_data, exp_head;
    int            obs_fill, exp_fill;

    always #5 clk = ~clk;

    bram_stream_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .READ_LATENCY(1), .ALMOST_FULL(AF)) u_dut_l1 (
        .clk(clk), .rst(rst), .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]),
        .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .fill(fill[0]),
        .almost_full(almost_full[0])
    );

    bram_stream_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .READ_LATENCY(2), .ALMOST_FULL(AF)) u_dut_l2 (
        .clk(clk), .rst(rst), .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]),
        .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .fill(fill[1]),
        .almost_full(almost_full[1])
    );

    // Sample between edges, then advance the reference queue across the next rising edge.
    task automatic tick(input int k);
        @(negedge clk);
        s_acc     = s_tvalid[k] && s_tready[k];
        m_pop     = m_tvalid[k] && m_tready[k];
        obs_valid = m_tvalid[k];
        obs_ready = s_tready[k];
        obs_af    = almost_full[k];
        obs_data  = m_tdata[k];
        obs_fill  = int'(fill[k]);
        exp_fill  = q.size();
        exp_head  = (q.size() != 0) ? q[0] : '0;
        @(posedge clk);
        if (m_pop && q.size() != 0) void'(q.pop_front());
        if (s_acc) q.push_back(s_tdata[k]);
        #1;
    endtask

    task automatic idle(input int k);
        s_tvalid[k] = 1'b0;
        m_tready[k] = 1'b0;
        s_tdata[k]  = '0;
    endtask

    task automatic test_reset(input int k);
        idle(k);
        rst = 1'b1;
        q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (s_tready[k] !== 1'b0) begin errors++; $display("FAIL reset_s_tready rl=%0d got %0b expected 0", k+1, s_tready[k]); end
        checks++; if (m_tvalid[k] !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid rl=%0d got %0b expected 0", k+1, m_tvalid[k]); end
        checks++; if (fill[k] !== '0) begin errors++; $display("FAIL reset_fill rl=%0d got %0d expected 0", k+1, fill[k]); end
        checks++; if (almost_full[k] !== 1'b0) begin errors++; $display("FAIL reset_almost_full rl=%0d got %0b expected 0", k+1, almost_full[k]); end
        checks++; if (m_tdata[k] !== '0) begin errors++; $display("FAIL reset_m_tdata rl=%0d got %0h expected 0", k+1, m_tdata[k]); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (s_tready[k] !== 1'b0) begin errors++; $display("FAIL ready_before_edge rl=%0d got %0b expected 0", k+1, s_tready[k]); end
        @(posedge clk); #1;
        checks++; if (s_tready[k] !== 1'b1) begin errors++; $display("FAIL ready_after_edge rl=%0d got %0b expected 1", k+1, s_tready[k]); end
    endtask

    task automatic test_latency(input int k);
        int lat;
        bit seen;
        s_tdata[k]  = 32'hA5A5_0001;
        s_tvalid[k] = 1'b1;
        m_tready[k] = 1'b1;
        tick(k);
        checks++; if (!s_acc) begin errors++; $display("FAIL lat_accept rl=%0d got %0b expected 1", k+1, s_acc); end
        s_tvalid[k] = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(k);
            if (obs_valid) seen = 1'b1;
            else lat++;
        end
        checks++; if (lat != k + 3) begin errors++; $display("FAIL lat_cycles rl=%0d got %0d expected %0d", k+1, lat, k+3); end
        checks++; if (obs_data !== 32'hA5A5_0001) begin errors++; $display("FAIL lat_data rl=%0d got %0h expected a5a50001", k+1, obs_data); end
        tick(k);
        checks++; if (obs_fill != 0 || obs_valid) begin errors++; $display("FAIL lat_drained rl=%0d got fill %0d valid %0b expected 0 0", k+1, obs_fill, obs_valid); end
        m_tready[k] = 1'b0;
    endtask

    task automatic test_stream(input int k);
        int total, sent, got, bad, gaps, fbad;
        bit started;
        logic [DW-1:0] base;
        total = 4 * DEPTH;
        sent = 0; got = 0; bad = 0; gaps = 0; fbad = 0; started = 1'b0;
        base = $urandom;
        m_tready[k] = 1'b1;
        s_tvalid[k] = 1'b1;
        s_tdata[k]  = base;
        for (int i = 0; i < total + 40 && got < total; i++) begin
            tick(k);
            if (obs_fill != exp_fill) fbad++;
            if (m_pop) begin
                if (obs_data !== base + DW'(got)) bad++;
                got++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            if (s_acc) begin
                sent++;
                s_tdata[k] = base + DW'(sent);
            end
            if (sent == total) s_tvalid[k] = 1'b0;
        end
        s_tvalid[k] = 1'b0;
        m_tready[k] = 1'b0;
        checks++; if (got != total) begin errors++; $display("FAIL stream_count rl=%0d got %0d expected %0d", k+1, got, total); end
        checks++; if (bad != 0) begin errors++; $display("FAIL stream_data rl=%0d got %0d bad words expected 0", k+1, bad); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps rl=%0d got %0d bubbles expected 0", k+1, gaps); end
        checks++; if (fbad != 0) begin errors++; $display("FAIL stream_fill rl=%0d got %0d wrong cycles expected 0", k+1, fbad); end
    endtask

    task automatic test_full(input int k);
        int skid, acc, afbad, rdybad, fbad, bad;
        skid = k + 3;
        acc = 0; afbad = 0; rdybad = 0; fbad = 0; bad = 0;
        m_tready[k] = 1'b0;
        s_tvalid[k] = 1'b1;
        for (int i = 0; i < DEPTH + skid + 20; i++) begin
            s_tdata[k] = $urandom;
            tick(k);
            if (s_acc) acc++;
            if (obs_fill != exp_fill) fbad++;
            if (exp_fill >= skid + 4) begin
                if (obs_af != (exp_fill - skid >= AF)) afbad++;
                if (obs_ready != (exp_fill < DEPTH + skid)) rdybad++;
            end
        end
        checks++; if (acc != DEPTH + skid) begin errors++; $display("FAIL full_accepted rl=%0d got %0d expected %0d", k+1, acc, DEPTH+skid); end
        checks++; if (int'(fill[k]) != DEPTH + skid) begin errors++; $display("FAIL full_fill rl=%0d got %0d expected %0d", k+1, fill[k], DEPTH+skid); end
        checks++; if (s_tready[k] !== 1'b0) begin errors++; $display("FAIL full_s_tready rl=%0d got %0b expected 0", k+1, s_tready[k]); end
        checks++; if (almost_full[k] !== 1'b1) begin errors++; $display("FAIL full_almost_full rl=%0d got %0b expected 1", k+1, almost_full[k]); end
        checks++; if (afbad != 0) begin errors++; $display("FAIL almost_full_edge rl=%0d got %0d wrong cycles expected 0", k+1, afbad); end
        checks++; if (rdybad != 0) begin errors++; $display("FAIL full_ready_track rl=%0d got %0d wrong cycles expected 0", k+1, rdybad); end
        checks++; if (fbad != 0) begin errors++; $display("FAIL full_fill_track rl=%0d got %0d wrong cycles expected 0", k+1, fbad); end
        s_tvalid[k] = 1'b0;
        m_tready[k] = 1'b1;
        for (int i = 0; i < DEPTH + skid + 40 && q.size() != 0; i++) begin
            tick(k);
            if (m_pop && obs_data !== exp_head) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_drain_order rl=%0d got %0d bad words expected 0", k+1, bad); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL full_drain_left rl=%0d got %0d words expected 0", k+1, q.size()); end
        tick(k);
        checks++; if (obs_fill != 0) begin errors++; $display("FAIL full_drain_fill rl=%0d got %0d expected 0", k+1, obs_fill); end
        m_tready[k] = 1'b0;
    endtask

    task automatic test_hold(input int k);
        int hbad;
        bit seen;
        logic [DW-1:0] h0;
        m_tready[k] = 1'b0;
        s_tvalid[k] = 1'b1;
        repeat (6) begin
            s_tdata[k] = $urandom;
            tick(k);
        end
        s_tvalid[k] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(k);
            if (obs_valid) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL hold_valid rl=%0d got 0 expected 1", k+1); end
        h0 = obs_data;
        checks++; if (h0 !== exp_head) begin errors++; $display("FAIL hold_head rl=%0d got %0h expected %0h", k+1, h0, exp_head); end
        hbad = 0;
        repeat (10) begin
            tick(k);
            if (!obs_valid || obs_data !== h0) hbad++;
        end
        checks++; if (hbad != 0) begin errors++; $display("FAIL hold_stable rl=%0d got %0d changed cycles expected 0", k+1, hbad); end
        m_tready[k] = 1'b1;
        tick(k);
        checks++; if (!m_pop || obs_data !== h0) begin errors++; $display("FAIL hold_release rl=%0d got %0h expected %0h", k+1, obs_data, h0); end
        tick(k);
        checks++; if (!obs_valid || obs_data !== exp_head) begin errors++; $display("FAIL hold_next rl=%0d got %0h expected %0h", k+1, obs_data, exp_head); end
        for (int i = 0; i < 40 && q.size() != 0; i++) tick(k);
        m_tready[k] = 1'b0;
    endtask

    task automatic test_reset_mid(input int k);
        int sent, got, bad, stale, fbad;
        logic [DW-1:0] base;
        m_tready[k] = 1'b1;
        s_tvalid[k] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_tdata[k] = 32'hDEAD_0000 + DW'(i);
            tick(k);
        end
        rst = 1'b1;
        #1;
        checks++; if (m_tvalid[k] !== 1'b0) begin errors++; $display("FAIL midrst_m_tvalid rl=%0d got %0b expected 0", k+1, m_tvalid[k]); end
        checks++; if (fill[k] !== '0) begin errors++; $display("FAIL midrst_fill rl=%0d got %0d expected 0", k+1, fill[k]); end
        checks++; if (s_tready[k] !== 1'b0) begin errors++; $display("FAIL midrst_s_tready rl=%0d got %0b expected 0", k+1, s_tready[k]); end
        q.delete();
        s_tvalid[k] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        base = 32'h5A00_0000;
        sent = 0; got = 0; bad = 0; stale = 0; fbad = 0;
        s_tvalid[k] = 1'b1;
        s_tdata[k]  = base;
        for (int i = 0; i < 100 && got < 30; i++) begin
            tick(k);
            if (obs_valid && exp_fill == 0) stale++;
            if (obs_fill != exp_fill) fbad++;
            if (m_pop) begin
                if (obs_data !== base + DW'(got)) bad++;
                got++;
            end
            if (s_acc) begin
                sent++;
                s_tdata[k] = base + DW'(sent);
            end
            if (sent == 30) s_tvalid[k] = 1'b0;
        end
        s_tvalid[k] = 1'b0;
        m_tready[k] = 1'b0;
        checks++; if (got != 30) begin errors++; $display("FAIL midrst_count rl=%0d got %0d expected 30", k+1, got); end
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_data rl=%0d got %0d bad words expected 0", k+1, bad); end
        checks++; if (stale != 0 || fbad != 0) begin errors++; $display("FAIL midrst_stale rl=%0d got %0d stale %0d fill errors expected 0", k+1, stale, fbad); end
    endtask

    task automatic test_random(input int k);
        int skid, bad, fbad, ovf, stale;
        skid = k + 3;
        bad = 0; fbad = 0; ovf = 0; stale = 0;
        for (int i = 0; i < 12000; i++) begin
            s_tvalid[k] = 1'($urandom_range(0, 1));
            m_tready[k] = ($urandom_range(0, 9) < 3);
            s_tdata[k]  = $urandom;
            tick(k);
            if (m_pop && obs_data !== exp_head) bad++;
            if (obs_valid && exp_fill == 0) stale++;
            if (obs_fill != exp_fill) fbad++;
            if (obs_fill > DEPTH + skid) ovf++;
        end
        s_tvalid[k] = 1'b0;
        m_tready[k] = 1'b1;
        for (int i = 0; i < DEPTH + skid + 40 && q.size() != 0; i++) begin
            tick(k);
            if (m_pop && obs_data !== exp_head) bad++;
            if (obs_fill != exp_fill) fbad++;
        end
        m_tready[k] = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL random_data rl=%0d got %0d bad words expected 0", k+1, bad); end
        checks++; if (fbad != 0) begin errors++; $display("FAIL random_fill rl=%0d got %0d wrong cycles expected 0", k+1, fbad); end
        checks++; if (ovf != 0) begin errors++; $display("FAIL skid_overflow rl=%0d got %0d cycles expected 0", k+1, ovf); end
        checks++; if (stale != 0) begin errors++; $display("FAIL random_stale rl=%0d got %0d cycles expected 0", k+1, stale); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL random_drain rl=%0d got %0d words left expected 0", k+1, q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        idle(0);
        idle(1);
        for (int k = 0; k < 2; k++) begin
            test_reset(k);
            test_latency(k);
            test_stream(k);
            test_full(k);
            test_hold(k);
            test_reset_mid(k);
            test_random(k);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
